wishbone_shared_bus: RTL
========================

# wishbone_shared_bus

Parametrised Wishbone B4 classic shared-bus interconnect. It connects NUM_MASTERS masters to NUM_SLAVES slaves through a single arbitrated bus. Ownership is granted round-robin, the owning master's address is decoded to one slave, and the block returns ACK, or ERR for unmapped addresses and for slaves that do not answer within TIMEOUT cycles. It replaces the fixed one-master/one-slave point-to-point wiring used between the Wishbone master and slave today.

## Interface
Clocking and reset: one clock, CLK_I. Reset is RST_I, synchronous and active-low.

Parameters:
- NUM_MASTERS, 2: number of masters (≥1)
- NUM_SLAVES, 4: number of slaves (≥1)
- DATA_WIDTH, 32: data bus width
- ADR_WIDTH, 8: address width
- SEL_WIDTH, DATA_WIDTH/8: byte-select width
- TIMEOUT, 16: cycles of STB without slave ACK before ERR (≥2)

Ports (master i occupies slice i of each flattened vector):
- CLK_I  in  1  clock
- RST_I  in  1  synchronous active-low reset
- M_CYC_I  in  NUM_MASTERS  bus request / cycle valid
- M_STB_I  in  NUM_MASTERS  strobe
- M_WE_I  in  NUM_MASTERS  write enable
- M_ADR_I  in  NUM_MASTERS*ADR_WIDTH  addresses
- M_DATA_I  in  NUM_MASTERS*DATA_WIDTH  write data
- M_SEL_I  in  NUM_MASTERS*SEL_WIDTH  byte selects
- M_DATA_O  out  DATA_WIDTH  read data, shared by all masters
- M_ACK_O  out  NUM_MASTERS  per-master acknowledge
- M_ERR_O  out  NUM_MASTERS  per-master error
- M_GNT_O  out  NUM_MASTERS  one-hot grant (debug/status)
- S_CYC_O  out  NUM_SLAVES  per-slave cycle
- S_STB_O  out  NUM_SLAVES  per-slave strobe
- S_WE_O  out  1  write enable of the granted master
- S_ADR_O  out  ADR_WIDTH  address of the granted master
- S_DATA_O  out  DATA_WIDTH  write data of the granted master
- S_SEL_O  out  SEL_WIDTH  byte selects of the granted master
- S_DATA_I  in  NUM_SLAVES*DATA_WIDTH  slave read data
- S_ACK_I  in  NUM_SLAVES  slave acknowledge

## Operation
Arbiter FSM has two states.
- IDLE: no grant. If any M_CYC_I is high, pick the first requester searching upward from last_gnt+1, with wrap-around. Register it as gnt and move to OWNED.
- OWNED: held while M_CYC_I[gnt] is high, regardless of other requests. When M_CYC_I[gnt] is low, go to IDLE and set last_gnt = gnt.

Decode:
- Slave index = ADR[ADR_WIDTH-1 -: clog2(NUM_SLAVES)] of the granted master. When NUM_SLAVES=1 the index is always 0.
- An index ≥ NUM_SLAVES is unmapped.

Routing in OWNED (combinational from the registered gnt):
- S_CYC_O[idx] and S_STB_O[idx] follow the granted master's CYC and STB. All other S_CYC_O/S_STB_O are 0.
- M_ACK_O[gnt] = STB & S_ACK_I[idx]. M_DATA_O = S_DATA_I[idx].
- Unmapped address with STB high: no slave strobed, M_ERR_O[gnt] = 1 in the same cycle.
- Timeout: a counter increments each cycle that the granted STB is high and no ACK is returned. It clears on ACK, on STB low, or on leaving OWNED.
  - When the counter reaches TIMEOUT-1, M_ERR_O[gnt] pulses for one cycle, S_STB_O is forced low for that cycle, and the counter clears.
  - A late slave ACK arriving in the ERR cycle is dropped.
- ACK and ERR are never asserted together. Non-granted masters always see ACK=0 and ERR=0.
- S_ADR_O, S_DATA_O, S_SEL_O and S_WE_O carry the granted master's values. In IDLE they carry master 0's values and are don't-care.

Reset (RST_I low at a clock edge):
- state=IDLE, last_gnt=NUM_MASTERS-1 (master 0 wins first), counter=0.
- All M_GNT_O, M_ACK_O, M_ERR_O, S_CYC_O and S_STB_O are 0.
- A reset mid-transfer drops the transfer with no ACK or ERR.

## Timing
- Grant latency: CYC rises at edge t in IDLE → M_GNT_O and S_CYC_O/S_STB_O are high after edge t+1.
- ACK and decode ERR: zero-cycle combinational paths from slave to master.
- Release: M_CYC_I[gnt] low at edge t → IDLE after t+1. The next grant is visible after t+2, so there is one dead cycle between owners.
- Timeout ERR asserts during the TIMEOUT-th consecutive unacked STB cycle.
- Block and burst cycles are supported: the master keeps CYC high and the grant persists across multiple STB/ACK beats.

## Test plan
- Single write: master 0 writes 0xDEADBEEF to ADR 0x40 (slave 1), and the slave ACKs on its first STB cycle → S_STB_O=4'b0010, S_DATA_O=0xDEADBEEF, M_ACK_O=2'b01 in that cycle, 2 cycles from CYC to ACK.
- Round-robin: both masters hold CYC continuously and each drops CYC after one transfer → grants alternate 0,1,0,1 with one idle cycle between grants.
- Unmapped address: NUM_SLAVES=3, master 1 reads ADR 0xC0 → no S_STB_O asserted, M_ERR_O=2'b10 while STB is high, M_ACK_O=0.
- Timeout: slave 2 never ACKs, TIMEOUT=16 → M_ERR_O pulses on the 16th STB cycle. S_STB_O[2]=0 that cycle and the counter restarts.
- Burst hold: master 1 performs 4 back-to-back reads with CYC held while master 0 requests → M_GNT_O stays 2'b10 for all 4 ACKs, and master 0 is granted 2 cycles after master 1 drops CYC.
- Reset mid-cycle: RST_I low while master 0 waits on slave 0 → after the next edge all S_CYC_O, S_STB_O, M_GNT_O, M_ACK_O and M_ERR_O are 0, and after release master 0 is granted first.

Source files
------------

// File: rtl/wishbone_shared_bus.sv
// wishbone_shared_bus: Wishbone B4 classic shared-bus interconnect.
// NUM_MASTERS masters share one bus. Ownership is granted round-robin, and the
// owner's address selects one slave. The owner gets ACK from that slave, or ERR
// for an unmapped address or for a slave that stays silent for TIMEOUT cycles.
//
// Handshake: a beat is offered while CYC & STB are high. It completes in the
// cycle where ACK or ERR is high; ACK and ERR are never high together. The
// master holds its request fields stable until the beat completes. CYC held
// high keeps the grant across beats, which is how bursts and block cycles work.
module wishbone_shared_bus #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADR_WIDTH   = 8,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  input  logic [NUM_MASTERS-1:0]            M_CYC_I,
  input  logic [NUM_MASTERS-1:0]            M_STB_I,
  input  logic [NUM_MASTERS-1:0]            M_WE_I,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0]  M_ADR_I,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_DATA_I,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  M_SEL_I,
  output logic [DATA_WIDTH-1:0]             M_DATA_O,
  output logic [NUM_MASTERS-1:0]            M_ACK_O,
  output logic [NUM_MASTERS-1:0]            M_ERR_O,
  output logic [NUM_MASTERS-1:0]            M_GNT_O,
  output logic [NUM_SLAVES-1:0]             S_CYC_O,
  output logic [NUM_SLAVES-1:0]             S_STB_O,
  output logic                              S_WE_O,
  output logic [ADR_WIDTH-1:0]              S_ADR_O,
  output logic [DATA_WIDTH-1:0]             S_DATA_O,
  output logic [SEL_WIDTH-1:0]              S_SEL_O,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  S_DATA_I,
  input  logic [NUM_SLAVES-1:0]             S_ACK_I
);

  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int DEC_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
  localparam int SIDX_W = (DEC_W > 0) ? DEC_W : 1;
  localparam int CNT_W  = $clog2(TIMEOUT);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              state, state_nxt;
  logic [MIDX_W-1:0]   gnt, gnt_nxt, last_gnt, last_gnt_nxt;
  logic [MIDX_W-1:0]   pick, pick_lo, pick_hi, mux_idx;
  logic                found_lo, found_hi, pick_valid;
  logic [CNT_W-1:0]    cnt;
  logic                owned, g_cyc, g_stb;
  logic [ADR_WIDTH-1:0] g_adr;
  logic [SIDX_W-1:0]   dec_idx, data_idx;
  logic                mapped, dec_err, to_err, ack_hit;

  assign owned   = (state == OWNED);
  // Outside OWNED the request fields fall back to master 0.
  assign mux_idx = owned ? gnt : '0;
  assign g_cyc   = owned & M_CYC_I[mux_idx];
  assign g_stb   = g_cyc & M_STB_I[mux_idx];
  assign g_adr   = M_ADR_I[int'(mux_idx)*ADR_WIDTH +: ADR_WIDTH];

  assign S_WE_O   = M_WE_I[mux_idx];
  assign S_ADR_O  = g_adr;
  assign S_DATA_O = M_DATA_I[int'(mux_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign S_SEL_O  = M_SEL_I[int'(mux_idx)*SEL_WIDTH +: SEL_WIDTH];

  // Top address bits select the slave; a single slave needs no decode.
  generate
    if (DEC_W > 0) begin : g_dec
      assign dec_idx = g_adr[ADR_WIDTH-1 -: DEC_W];
    end else begin : g_no_dec
      assign dec_idx = '0;
    end
  endgenerate

  assign mapped   = (int'(dec_idx) < NUM_SLAVES);
  assign data_idx = mapped ? dec_idx : '0;
  assign dec_err  = g_stb & ~mapped;
  // The TIMEOUT-th unacked STB cycle reports ERR and swallows any late ACK.
  assign to_err   = g_stb & mapped & (cnt == CNT_W'(TIMEOUT - 1));
  assign ack_hit  = g_stb & mapped & ~to_err & S_ACK_I[data_idx];
  assign M_DATA_O = S_DATA_I[int'(data_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin pick: first requester above last_gnt, else the lowest requester.
  always_comb begin
    pick_lo  = '0;
    pick_hi  = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int c = NUM_MASTERS - 1; c >= 0; c--) begin
      if (M_CYC_I[c]) begin
        found_lo = 1'b1;
        pick_lo  = MIDX_W'(c);
        if (c > int'(last_gnt)) begin
          found_hi = 1'b1;
          pick_hi  = MIDX_W'(c);
        end
      end
    end
    pick       = found_hi ? pick_hi : pick_lo;
    pick_valid = found_lo;
  end

  // Arbiter next state: grant from IDLE, hold while the owner keeps CYC.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = OWNED;
          gnt_nxt   = pick;
        end
      end
      OWNED: begin
        if (!M_CYC_I[gnt]) begin
          state_nxt    = IDLE;
          last_gnt_nxt = gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter registers; reset makes master 0 the first winner.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= MIDX_W'(NUM_MASTERS - 1);
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Timeout counter: counts unanswered STB cycles of the owner.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      cnt <= '0;
    end else if (!g_stb || ack_hit || dec_err || to_err) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Routing of strobes and responses, all driven from the registered grant.
  always_comb begin
    S_CYC_O = '0;
    S_STB_O = '0;
    M_ACK_O = '0;
    M_ERR_O = '0;
    M_GNT_O = '0;
    if (owned) begin
      M_GNT_O[gnt] = 1'b1;
      if (mapped) begin
        S_CYC_O[data_idx] = g_cyc;
        S_STB_O[data_idx] = g_stb & ~to_err;
      end
      M_ACK_O[gnt] = ack_hit;
      M_ERR_O[gnt] = dec_err | to_err;
    end
  end

endmodule
